// File: rtl/seq_pkg.sv
// Shared definitions for the bit-serializer.
//   SEQ_WORD_W : default parallel word width
//   state_t    : shifter occupancy state (IDLE = shifter empty, SHIFT = word loaded)
package seq_pkg;

    localparam int SEQ_WORD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer, feeding a
// downstream sequence detector one bit per shift_en strobe.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous active-high reset
//   data_in    in   [WIDTH-1:0] parallel word
//   data_valid in   data_in is offered
//   data_ready out  a word can be accepted this cycle (= !hold_full)
//   shift_en   in   downstream advance; bit consumed when ser_valid && shift_en
//   ser_out    out  serial bit (0 when ser_valid=0)
//   ser_valid  out  ser_out carries a word bit
//   word_last  out  ser_out carries the final bit of a word
//   idle       out  shifter and hold buffer both empty
module seq_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = SEQ_WORD_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_last,
    output logic             idle
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] hold, hold_nxt;
    logic             hold_full, hold_full_nxt;
    logic [CW-1:0]    count, count_nxt;

    logic accept;
    logic consume;

    // Move the next bit into the output position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        if (MSB_FIRST)
            return {v[WIDTH-2:0], 1'b0};
        else
            return {1'b0, v[WIDTH-1:1]};
    endfunction

    assign ser_valid  = (state == SHIFT);
    assign ser_out    = ser_valid & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign word_last  = ser_valid && (count == LAST_CNT);
    assign data_ready = !hold_full;
    assign idle       = (state == IDLE) && !hold_full;

    assign accept  = data_valid && data_ready;
    assign consume = ser_valid && shift_en;

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        count_nxt     = count;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    shreg_nxt = data_in;
                    count_nxt = '0;
                end
            end
            SHIFT: begin
                if (consume && word_last) begin
                    count_nxt = '0;
                    // A full hold buffer blocks accept, so at most one of
                    // these two refill sources is active.
                    if (hold_full) begin
                        shreg_nxt     = hold;
                        hold_full_nxt = 1'b0;
                    end else if (accept) begin
                        shreg_nxt = data_in;
                    end else begin
                        state_nxt = IDLE;
                        shreg_nxt = '0;
                    end
                end else begin
                    if (consume) begin
                        shreg_nxt = advance(shreg);
                        count_nxt = count + 1'b1;
                    end
                    if (accept) begin
                        hold_nxt      = data_in;
                        hold_full_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            count     <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            count     <= count_nxt;
            hold_full <= hold_full_nxt;
        end
    end

    // Hold contents are only meaningful while hold_full is set.
    always_ff @(posedge clk) begin
        hold <= hold_nxt;
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Randomized scoreboard bench for seq_serializer: an MSB-first and an
// LSB-first instance share one stimulus stream; accepted words are expanded
// into expected bit queues and a negedge monitor checks every output.
module tb_seq_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         shift_en = 1'b0;

    logic ser_out_m, ser_valid_m, word_last_m, data_ready_m, idle_m;
    logic ser_out_l, ser_valid_l, word_last_l, data_ready_l, idle_l;

    int  total = 0;
    int  passed = 0;
    bit  armed = 1'b0;
    bit  mdl_ready = 1'b1;
    bit  last_acc = 1'b0;
    logic qm[$];
    logic ql[$];

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready_m), .shift_en(shift_en), .ser_out(ser_out_m),
        .ser_valid(ser_valid_m), .word_last(word_last_m), .idle(idle_m)
    );

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready_l), .shift_en(shift_en), .ser_out(ser_out_l),
        .ser_valid(ser_valid_l), .word_last(word_last_l), .idle(idle_l)
    );

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        else
            passed++;
    endtask

    // Monitor: everything pending forms a bit queue; the shifter word owns the
    // first (size mod W, or W) bits, a held word the remaining W.
    always @(negedge clk) begin
        if (armed) begin
            if (reset) begin
                qm.delete();
                ql.delete();
                mdl_ready = 1'b1;
            end else begin
                logic ev, el;
                ev = (qm.size() > 0);
                el = ev && ((qm.size() % W) == 1);
                check("ser_valid_msb", ser_valid_m, ev);
                check("ser_valid_lsb", ser_valid_l, ev);
                check("ser_out_msb", ser_out_m, ev ? qm[0] : 1'b0);
                check("ser_out_lsb", ser_out_l, ev ? ql[0] : 1'b0);
                check("word_last_msb", word_last_m, el);
                check("word_last_lsb", word_last_l, el);
                check("data_ready_msb", data_ready_m, qm.size() <= W);
                check("data_ready_lsb", data_ready_l, qm.size() <= W);
                check("idle_msb", idle_m, qm.size() == 0);
                check("idle_lsb", idle_l, qm.size() == 0);
                mdl_ready = (qm.size() <= W);
                if (ev && shift_en) begin
                    void'(qm.pop_front());
                    void'(ql.pop_front());
                end
            end
        end
    end

    // Drive one cycle; on acceptance push the word's bits in both orders.
    task automatic step(input logic dv, input logic [W-1:0] din, input logic se, input logic rst);
        data_valid = dv;
        data_in    = din;
        shift_en   = se;
        reset      = rst;
        @(posedge clk);
        last_acc = !reset && data_valid && mdl_ready;
        if (last_acc) begin
            for (int i = W - 1; i >= 0; i--) qm.push_back(data_in[i]);
            for (int i = 0; i < W; i++) ql.push_back(data_in[i]);
        end
        #1;
    endtask

    task automatic send(input logic [W-1:0] w, input logic se);
        int n;
        n = 0;
        do begin
            step(1'b1, w, se, 1'b0);
            n++;
        end while (!last_acc && n < 40);
        if (!last_acc) begin
            total++;
            $display("FAIL send_timeout: word %h got not-accepted expected accepted", w);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (qm.size() > 0 && n < 60) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        step(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (qm.size() != 0)
            $display("FAIL drain_timeout: got %0d bits pending expected 0", qm.size());
        else
            passed++;
    endtask

    initial begin
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        armed = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0);

        // Single word, shift every cycle
        send(8'hD0, 1'b1);
        drain();

        // Back-to-back words, no gap
        send(8'hD0, 1'b1);
        send(8'hE0, 1'b1);
        drain();

        // Stall after the second bit
        send(8'hE0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        drain();

        // Hold buffer fills, third word blocked while stalled
        step(1'b1, 8'hA1, 1'b0, 1'b0);
        step(1'b1, 8'hB2, 1'b0, 1'b0);
        repeat (3) step(1'b1, 8'hC3, 1'b0, 1'b0);
        send(8'hC3, 1'b1);
        drain();

        // Reset mid-word with a held word
        send(8'hD0, 1'b1);
        send(8'hE0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);

        // Bit-order pattern for the LSB-first instance
        send(8'h0B, 1'b1);
        drain();

        // Randomized traffic with occasional reset
        for (int c = 0; c < 800; c++) begin
            step(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 199) == 0));
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
